// File: rtl/jedro_2_csr_pkg.sv
// Shared definitions for the jedro_2 machine-mode CSR/trap unit: CSR addresses,
// cause codes, write-mode encoding and register bit positions.
package jedro_2_defines;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
    localparam logic [4:0] EXC_INSTR_FAULT    = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL_INSTR  = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
    localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
    localparam logic [4:0] EXC_LOAD_FAULT     = 5'd5;
    localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
    localparam logic [4:0] EXC_STORE_FAULT    = 5'd7;
    localparam logic [4:0] EXC_ECALL_M        = 5'd11;

    localparam logic [4:0] IRQ_CODE_MSI        = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI        = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI        = 5'd11;
    localparam logic [4:0] IRQ_CODE_LOCAL_BASE = 5'd16;

    typedef enum logic [1:0] {
        CSR_WMODE_NORMAL = 2'b00,
        CSR_WMODE_SET    = 2'b01,
        CSR_WMODE_CLEAR  = 2'b10
    } csr_wmode_e;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MSIE_BIT     = 3;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;
    localparam int unsigned MIE_LOCAL_BASE   = 16;
    localparam int unsigned MCNTINH_CY_BIT   = 0;
    localparam int unsigned MCNTINH_IR_BIT   = 2;

    localparam logic [1:0]  MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;
    localparam logic [31:0] MISA_RV32I          = 32'h4000_0100;

    function automatic logic [31:0] csr_apply(input csr_wmode_e mode,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (mode)
            CSR_WMODE_SET:   return old_val | wdata;
            CSR_WMODE_CLEAR: return old_val & ~wdata;
            default:         return wdata;
        endcase
    endfunction

endpackage

// File: rtl/jedro_2_csr_counter.sv
// Up-counter of up to 64 bits, writable per 32-bit half through the CSR port;
// a write to either half suppresses that cycle's increment.
module jedro_2_csr_counter
    import jedro_2_defines::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inhibit,
    input  logic             inc,
    input  logic             we_lo,
    input  logic             we_hi,
    input  csr_wmode_e       wmode,
    input  logic [31:0]      wdata,
    output logic [WIDTH-1:0] value
);

    logic [63:0] cur_ext;
    logic [63:0] wr_ext;

    // Work on a 64-bit view so narrower counters need no special slicing.
    always_comb begin
        cur_ext = 64'(value);
        wr_ext  = cur_ext;
        if (we_lo) wr_ext[31:0]  = csr_apply(wmode, cur_ext[31:0], wdata);
        if (we_hi) wr_ext[63:32] = csr_apply(wmode, cur_ext[63:32], wdata);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (we_lo || we_hi) begin
            value <= wr_ext[WIDTH-1:0];
        end else if (inc && !inhibit) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/jedro_2_csr.sv
// Machine-mode CSR file and trap unit: CSR access, counters, interrupt
// arbitration, trap entry/mret and a one-cycle fetch redirect.
module jedro_2_csr
    import jedro_2_defines::*;
#(
    parameter int unsigned  DATA_WIDTH    = 32,
    parameter int unsigned  COUNTER_WIDTH = 64,
    parameter int unsigned  NUM_LOCAL_IRQ = 4,
    parameter bit           VECTORED_EN   = 1'b1,
    parameter logic [29:0]  TRAP_VEC_BASE = 30'h0010_0000,
    localparam int unsigned LIRQ_W        = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    input  logic [1:0]            csr_wmode_i,
    input  logic                  csr_we_i,
    input  logic                  csr_re_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic                  csr_illegal_o,
    input  logic                  exc_i,
    input  logic [4:0]            exc_cause_i,
    input  logic [31:0]           trap_pc_i,
    input  logic [31:0]           trap_tval_i,
    input  logic                  irq_take_i,
    input  logic                  mret_i,
    input  logic                  instr_ret_i,
    input  logic                  irq_sw_i,
    input  logic                  irq_timer_i,
    input  logic                  irq_ext_i,
    input  logic [LIRQ_W-1:0]     irq_local_i,
    output logic                  irq_req_o,
    output logic                  redirect_o,
    output logic [31:0]           redirect_pc_o
);

    localparam logic [31:0] LOCAL_MASK =
        32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << MIE_LOCAL_BASE);
    localparam logic [31:0] MIE_MASK = LOCAL_MASK | (32'd1 << MIE_MEIE_BIT)
                                     | (32'd1 << MIE_MTIE_BIT) | (32'd1 << MIE_MSIE_BIT);

    csr_wmode_e               wmode;
    logic                     mstatus_mie_q, mstatus_mpie_q;
    logic                     inhibit_cy_q, inhibit_ir_q;
    logic [31:0]              mie_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [29:0]              mtvec_base_q;
    logic [1:0]               mtvec_mode_q;
    logic [31:0]              mip_val, pend, rd_val, wval, trap_base, redirect_tgt;
    logic [COUNTER_WIDTH-1:0] mcycle, minstret;
    logic [63:0]              mcycle_ext, minstret_ext;
    logic                     addr_known, access, illegal, csr_wr;
    logic                     take_exc, take_irq, take_mret, any_evt;
    logic [4:0]               irq_code;

    assign wmode        = csr_wmode_e'(csr_wmode_i);
    assign mcycle_ext   = 64'(mcycle);
    assign minstret_ext = 64'(minstret);

    // mip is a live view of the interrupt lines, so irq_req_o reacts in the same cycle.
    always_comb begin
        mip_val               = (32'(irq_local_i) << MIE_LOCAL_BASE) & LOCAL_MASK;
        mip_val[MIE_MSIE_BIT] = irq_sw_i;
        mip_val[MIE_MTIE_BIT] = irq_timer_i;
        mip_val[MIE_MEIE_BIT] = irq_ext_i;
    end

    assign pend      = mip_val & mie_q;
    assign irq_req_o = mstatus_mie_q & (|pend);

    // Lowest-priority sources are assigned first so higher ones override.
    always_comb begin
        irq_code = 5'd0;
        for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--) begin
            if (pend[MIE_LOCAL_BASE + i]) irq_code = 5'(int'(IRQ_CODE_LOCAL_BASE) + i);
        end
        if (pend[MIE_MTIE_BIT]) irq_code = IRQ_CODE_MTI;
        if (pend[MIE_MSIE_BIT]) irq_code = IRQ_CODE_MSI;
        if (pend[MIE_MEIE_BIT]) irq_code = IRQ_CODE_MEI;
    end

    always_comb begin
        rd_val     = '0;
        addr_known = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                rd_val[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                rd_val[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MISA:          rd_val = MISA_RV32I;
            CSR_MIE:           rd_val = mie_q;
            CSR_MTVEC:         rd_val = {mtvec_base_q, mtvec_mode_q};
            CSR_MCOUNTINHIBIT: begin
                rd_val[MCNTINH_CY_BIT] = inhibit_cy_q;
                rd_val[MCNTINH_IR_BIT] = inhibit_ir_q;
            end
            CSR_MSCRATCH:      rd_val = mscratch_q;
            CSR_MEPC:          rd_val = mepc_q;
            CSR_MCAUSE:        rd_val = mcause_q;
            CSR_MTVAL:         rd_val = mtval_q;
            CSR_MIP:           rd_val = mip_val;
            CSR_MCYCLE:        rd_val = mcycle_ext[31:0];
            CSR_MINSTRET:      rd_val = minstret_ext[31:0];
            CSR_MCYCLEH: begin
                rd_val     = mcycle_ext[63:32];
                addr_known = (COUNTER_WIDTH > 32);
            end
            CSR_MINSTRETH: begin
                rd_val     = minstret_ext[63:32];
                addr_known = (COUNTER_WIDTH > 32);
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rd_val = '0;
            default:           addr_known = 1'b0;
        endcase
    end

    assign access    = csr_re_i | csr_we_i;
    assign illegal   = access & (~addr_known | (csr_we_i & (csr_addr_i[11:10] == 2'b11)));
    assign take_exc  = exc_i;
    assign take_irq  = ~exc_i & irq_take_i & irq_req_o;
    assign take_mret = ~exc_i & ~take_irq & mret_i;
    assign any_evt   = take_exc | take_irq | take_mret;
    assign csr_wr    = csr_we_i & ~illegal & ~any_evt;
    assign wval      = csr_apply(wmode, rd_val, csr_wdata_i);
    assign trap_base = {mtvec_base_q, 2'b00};

    always_comb begin
        redirect_tgt = trap_base;
        if (take_irq && mtvec_mode_q == MTVEC_MODE_VECTORED) begin
            redirect_tgt = trap_base + {25'd0, irq_code, 2'b00};
        end else if (take_mret) begin
            redirect_tgt = mepc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            inhibit_cy_q   <= 1'b0;
            inhibit_ir_q   <= 1'b0;
            mie_q          <= '0;
            mtvec_base_q   <= TRAP_VEC_BASE;
            mtvec_mode_q   <= MTVEC_MODE_DIRECT;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else if (take_exc || take_irq) begin
            mepc_q         <= trap_pc_i & ~32'h3;
            mcause_q       <= take_exc ? {27'd0, exc_cause_i} : {1'b1, 26'd0, irq_code};
            mtval_q        <= take_exc ? trap_tval_i : '0;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (take_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (csr_wr) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_q  <= wval[MSTATUS_MIE_BIT];
                    mstatus_mpie_q <= wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:   mie_q <= wval & MIE_MASK;
                CSR_MTVEC: begin
                    mtvec_base_q <= wval[31:2];
                    // Unsupported MODE encodings keep the current mode.
                    if (wval[1:0] == MTVEC_MODE_DIRECT) begin
                        mtvec_mode_q <= MTVEC_MODE_DIRECT;
                    end else if (wval[1:0] == MTVEC_MODE_VECTORED && VECTORED_EN) begin
                        mtvec_mode_q <= MTVEC_MODE_VECTORED;
                    end
                end
                CSR_MCOUNTINHIBIT: begin
                    inhibit_cy_q <= wval[MCNTINH_CY_BIT];
                    inhibit_ir_q <= wval[MCNTINH_IR_BIT];
                end
                CSR_MSCRATCH: mscratch_q <= wval;
                CSR_MEPC:     mepc_q     <= wval & ~32'h3;
                CSR_MCAUSE:   mcause_q   <= wval;
                CSR_MTVAL:    mtval_q    <= wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            csr_rdata_o   <= '0;
            csr_illegal_o <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            if (access) begin
                csr_rdata_o   <= illegal ? '0 : rd_val;
                csr_illegal_o <= illegal;
            end
            redirect_o <= any_evt;
            if (any_evt) redirect_pc_o <= redirect_tgt;
        end
    end

    jedro_2_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .inhibit (inhibit_cy_q),
        .inc     (1'b1),
        .we_lo   (csr_wr && csr_addr_i == CSR_MCYCLE),
        .we_hi   (csr_wr && csr_addr_i == CSR_MCYCLEH),
        .wmode   (wmode),
        .wdata   (csr_wdata_i),
        .value   (mcycle)
    );

    jedro_2_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_minstret (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .inhibit (inhibit_ir_q),
        .inc     (instr_ret_i),
        .we_lo   (csr_wr && csr_addr_i == CSR_MINSTRET),
        .we_hi   (csr_wr && csr_addr_i == CSR_MINSTRETH),
        .wmode   (wmode),
        .wdata   (csr_wdata_i),
        .value   (minstret)
    );

endmodule

// File: tb/tb_jedro_2_csr.sv
// Scoreboard bench for jedro_2_csr: a behavioural CSR/trap model predicts read
// data and redirects; a separate monitor compares them as the DUT presents them.
module tb_jedro_2_csr;

    logic        clk = 1'b0;
    logic        rstn;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_wmode;
    logic        csr_we, csr_re;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exc;
    logic [4:0]  exc_cause;
    logic [31:0] trap_pc, trap_tval;
    logic        irq_take, mret, instr_ret;
    logic        irq_sw, irq_timer, irq_ext;
    logic [3:0]  irq_local;
    logic        irq_req, redirect;
    logic [31:0] redirect_pc;

    jedro_2_csr dut (
        .clk_i(clk), .rstn_i(rstn),
        .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_wmode_i(csr_wmode),
        .csr_we_i(csr_we), .csr_re_i(csr_re),
        .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
        .exc_i(exc), .exc_cause_i(exc_cause), .trap_pc_i(trap_pc), .trap_tval_i(trap_tval),
        .irq_take_i(irq_take), .mret_i(mret), .instr_ret_i(instr_ret),
        .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
        .irq_local_i(irq_local), .irq_req_o(irq_req),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] redir_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference state: architectural register values as plain words.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
    logic [63:0] m_cyc, m_ins;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic reset_model();
        m_mstatus = 0; m_mie = 0; m_mtvec = 32'h0040_0000; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [31:0] wapply(input logic [1:0] m, input logic [31:0] o, input logic [31:0] d);
        case (m)
            2'b01:   return o | d;
            2'b10:   return o & ~d;
            default: return d;
        endcase
    endfunction

    function automatic logic [4:0] pick(input logic [31:0] p);
        if (p[11]) return 5'd11;
        if (p[3])  return 5'd3;
        if (p[7])  return 5'd7;
        for (int i = 0; i < 16; i++) if (p[16+i]) return 5'(16 + i);
        return 5'd0;
    endfunction

    function automatic void model_read(input logic [11:0] a, input logic [31:0] mip,
                                       output logic known, output logic [31:0] v);
        known = 1'b1;
        v = 32'h0;
        case (a)
            12'h300: v = m_mstatus;
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h320: v = m_inh;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = mip;
            12'hB00: v = m_cyc[31:0];
            12'hB02: v = m_ins[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB82: v = m_ins[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 32'h0;
            default: known = 1'b0;
        endcase
    endfunction

    // One clock of stimulus: predict this cycle's effects, then let the edge happen.
    task automatic step();
        logic [31:0] mip, pend, val, wv, base;
        logic [63:0] nc, ni;
        logic        known, ill, req;
        logic [4:0]  code;
        #1;
        mip = 32'(irq_local) << 16;
        mip[3] = irq_sw; mip[7] = irq_timer; mip[11] = irq_ext;
        pend = mip & m_mie;
        req  = m_mstatus[3] && (pend != 0);
        chk("irq_req", 64'(irq_req), 64'(req));
        model_read(csr_addr, mip, known, val);
        ill = !known || (csr_we && csr_addr[11:10] == 2'b11);
        if (csr_re || csr_we) exp_q.push_back('{csr_addr, ill ? 32'h0 : val, ill});
        nc = m_inh[0] ? m_cyc : m_cyc + 64'd1;
        ni = (m_inh[2] || !instr_ret) ? m_ins : m_ins + 64'd1;
        base = m_mtvec & ~32'h3;
        if (exc) begin
            m_mepc = trap_pc & ~32'h3; m_mcause = {27'd0, exc_cause}; m_mtval = trap_tval;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            redir_q.push_back(base);
        end else if (irq_take && req) begin
            code = pick(pend);
            m_mepc = trap_pc & ~32'h3; m_mcause = 32'h8000_0000 | 32'(code); m_mtval = 0;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            redir_q.push_back(m_mtvec[1:0] == 2'b01 ? base + 4 * 32'(code) : base);
        end else if (mret) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            redir_q.push_back(m_mepc);
        end else if (csr_we && !ill) begin
            wv = wapply(csr_wmode, val, csr_wdata);
            case (csr_addr)
                12'h300: m_mstatus = wv & 32'h88;
                12'h304: m_mie = wv & 32'h000F_0888;
                12'h305: m_mtvec = {wv[31:2], (wv[1:0] == 2'b00) ? 2'b00 :
                                              (wv[1:0] == 2'b01) ? 2'b01 : m_mtvec[1:0]};
                12'h320: m_inh = wv & 32'h5;
                12'h340: m_mscratch = wv;
                12'h341: m_mepc = wv & ~32'h3;
                12'h342: m_mcause = wv;
                12'h343: m_mtval = wv;
                12'hB00: nc = {m_cyc[63:32], wv};
                12'hB80: nc = {wv, m_cyc[31:0]};
                12'hB02: ni = {m_ins[63:32], wv};
                12'hB82: ni = {wv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = nc;
        m_ins = ni;
        @(posedge clk);
        #1;
        csr_re = 0; csr_we = 0; exc = 0; irq_take = 0; mret = 0; instr_ret = 0;
    endtask

    task automatic csr_rd(input logic [11:0] a);
        csr_addr = a; csr_re = 1'b1;
        step();
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
        csr_addr = a; csr_wmode = m; csr_wdata = d; csr_we = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Monitor: read data appears the cycle after an access edge; redirects whenever pulsed.
    logic acc_seen = 1'b0;
    always @(posedge clk) acc_seen <= rstn && (csr_re || csr_we);

    always @(negedge clk) begin
        exp_t e;
        if (acc_seen) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 64'(csr_rdata), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("rdata@%h", e.addr), 64'(csr_rdata), 64'(e.rdata));
                chk($sformatf("illegal@%h", e.addr), 64'(csr_illegal), 64'(e.ill));
            end
        end
        if (rstn && redirect) begin
            if (redir_q.size() == 0) chk("redirect_spurious", 64'(redirect_pc), 64'hDEAD);
            else chk("redirect_pc", 64'(redirect_pc), 64'(redir_q.pop_front()));
        end
    end

    localparam logic [11:0] RND_ADDR [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320,
        12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
        12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123};

    initial begin
        rstn = 0; csr_addr = 0; csr_wdata = 0; csr_wmode = 0; csr_we = 0; csr_re = 0;
        exc = 0; exc_cause = 0; trap_pc = 0; trap_tval = 0; irq_take = 0; mret = 0;
        instr_ret = 0; irq_sw = 0; irq_timer = 0; irq_ext = 0; irq_local = 0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", 64'(csr_rdata), 0);
        chk("rst_illegal", 64'(csr_illegal), 0);
        chk("rst_redirect", 64'(redirect), 0);
        chk("rst_irq_req", 64'(irq_req), 0);
        rstn = 1;

        csr_rd(12'h305); csr_rd(12'hB00); csr_rd(12'h300);

        // Counter wrap across both halves.
        csr_wr(12'hB80, 2'b00, 32'hFFFF_FFFF);
        csr_wr(12'hB00, 2'b00, 32'hFFFF_FFFE);
        idle(2);
        csr_rd(12'hB00); csr_rd(12'hB80);

        // Inhibited minstret.
        csr_wr(12'h320, 2'b01, 32'h4);
        repeat (5) begin instr_ret = 1; step(); end
        csr_rd(12'hB02);
        csr_wr(12'h320, 2'b10, 32'h4);

        // Vectored timer interrupt.
        csr_wr(12'h305, 2'b00, 32'h0000_1001);
        csr_wr(12'h304, 2'b00, 32'h80);
        csr_wr(12'h300, 2'b01, 32'h8);
        irq_timer = 1; step();
        irq_take = 1; trap_pc = 32'h80; step();
        irq_timer = 0;
        csr_rd(12'h342); csr_rd(12'h341); csr_rd(12'h300);

        // Exception beats a simultaneous mret.
        csr_wr(12'h300, 2'b00, 32'h8);
        exc = 1; exc_cause = 5'd2; mret = 1; trap_pc = 32'h200; trap_tval = 32'h55; step();
        csr_rd(12'h342); csr_rd(12'h300); csr_rd(12'h343);
        mret = 1; step();
        irq_take = 1; step();

        // Illegal accesses leave state intact.
        csr_wr(12'hF11, 2'b00, 32'h1234);
        csr_rd(12'h7C0);
        csr_rd(12'hF11);

        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 3);
            csr_addr  = RND_ADDR[$urandom_range(0, 19)];
            csr_wmode = 2'($urandom_range(0, 2));
            csr_wdata = $urandom;
            csr_re    = (op == 1 || op == 3);
            csr_we    = (op == 2 || op == 3);
            exc       = ($urandom_range(0, 19) == 0);
            exc_cause = 5'($urandom);
            irq_take  = ($urandom_range(0, 9) == 0);
            mret      = ($urandom_range(0, 19) == 0);
            instr_ret = 1'($urandom);
            trap_pc   = $urandom;
            trap_tval = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                irq_sw = 1'($urandom); irq_timer = 1'($urandom);
                irq_ext = 1'($urandom); irq_local = 4'($urandom);
            end
            step();
        end
        irq_sw = 0; irq_timer = 0; irq_ext = 0; irq_local = 0;
        csr_wr(12'h340, 2'b00, 32'hDEAD_BEEF);
        idle(3);
        chk("rd_queue_drained", 64'(exp_q.size()), 0);
        chk("redir_queue_drained", 64'(redir_q.size()), 0);

        // Reset landing on an in-flight redirect pulse.
        exc = 1; exc_cause = 5'd5; trap_pc = 32'h400;
        @(posedge clk);
        #1;
        exc = 0;
        rstn = 0;
        #1;
        chk("midrst_redirect", 64'(redirect), 0);
        chk("midrst_rdata", 64'(csr_rdata), 0);
        chk("midrst_irq_req", 64'(irq_req), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        reset_model();
        csr_rd(12'h340); csr_rd(12'h341); csr_rd(12'h305); csr_rd(12'hB80);
        idle(2);
        chk("final_rd_queue", 64'(exp_q.size()), 0);
        chk("final_redir_queue", 64'(redir_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
